// File: rtl/tt_pll_pkg.sv
// rtl/tt_pll_pkg.sv - shared state enum, default constants and saturating add for the DCO loop
package tt_pll_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } loop_state_e;

  localparam int DEF_ACC_W    = 16;
  localparam int DEF_CTRL_W   = 10;
  localparam int DEF_BASE_FCW = 'h0400;
  localparam int DEF_KI       = 1;
  localparam int DEF_KP       = 16;
  localparam int DEF_LOCK_CNT = 256;

  // Widened to 64 bits so the sum itself can never overflow before clamping.
  function automatic int sat_add(input int a, input int b, input int lo, input int hi);
    longint s;
    s = longint'(a) + longint'(b);
    if (s > longint'(hi)) return hi;
    if (s < longint'(lo)) return lo;
    return int'(s);
  endfunction

endpackage

// File: rtl/tt_dco_nco.sv
// rtl/tt_dco_nco.sv - clamped FCW, phase accumulator and registered feedback clock
module tt_dco_nco
  import tt_pll_pkg::*;
#(
  parameter int ACC_W    = DEF_ACC_W,
  parameter int CTRL_W   = DEF_CTRL_W,
  parameter int BASE_FCW = DEF_BASE_FCW,
  parameter int KP       = DEF_KP
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_run,
  input  logic              i_up,
  input  logic              i_down,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_clk_fb
);

  localparam logic signed [ACC_W+1:0] BASE_W  = (ACC_W+2)'(BASE_FCW);
  localparam logic signed [ACC_W+1:0] KP_W    = (ACC_W+2)'(KP);
  localparam logic signed [ACC_W+1:0] FCW_MIN = (ACC_W+2)'(1);
  localparam logic signed [ACC_W+1:0] FCW_MAX = (ACC_W+2)'((2**(ACC_W-1)) - 1);

  logic signed [ACC_W+1:0] prop;
  logic signed [ACC_W+1:0] fcw_wide;
  logic [ACC_W-1:0]        fcw;
  logic [ACC_W-1:0]        phase_q, phase_d;
  logic                    clk_fb_q;

  // Upper clamp keeps the output at or below half the system clock rate.
  always_comb begin
    prop = '0;
    if (i_up) begin
      prop = KP_W;
    end else if (i_down) begin
      prop = -KP_W;
    end
    fcw_wide = BASE_W + (ACC_W+2)'($signed(i_ctrl)) + prop;
    if (fcw_wide < FCW_MIN) begin
      fcw = ACC_W'(1);
    end else if (fcw_wide > FCW_MAX) begin
      fcw = ACC_W'((2**(ACC_W-1)) - 1);
    end else begin
      fcw = fcw_wide[ACC_W-1:0];
    end
  end

  always_comb begin
    phase_d = phase_q;
    if (i_run) begin
      phase_d = phase_q + fcw;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      phase_q  <= '0;
      clk_fb_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      clk_fb_q <= phase_q[ACC_W-1];
    end
  end

  assign o_clk_fb = clk_fb_q;

endmodule

// File: rtl/tt_dco_loop.sv
// rtl/tt_dco_loop.sv - digital PLL loop: acquire/lock FSM, integral word, lock detect and scan chain
module tt_dco_loop
  import tt_pll_pkg::*;
#(
  parameter int ACC_W    = DEF_ACC_W,
  parameter int CTRL_W   = DEF_CTRL_W,
  parameter int BASE_FCW = DEF_BASE_FCW,
  parameter int KI       = DEF_KI,
  parameter int KP       = DEF_KP,
  parameter int LOCK_CNT = DEF_LOCK_CNT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_up,
  input  logic              i_down,
  output logic              o_clk_fb,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_lock,
  input  logic              i_scan_en,
  input  logic              i_scan_in,
  output logic              o_scan_out
);

  localparam int CTRL_MAX = (2**(CTRL_W-1)) - 1;
  localparam int CTRL_MIN = -(2**(CTRL_W-1));
  localparam int Q_W      = $clog2(LOCK_CNT + 1);
  localparam logic [Q_W-1:0] QUIET_FULL = Q_W'(LOCK_CNT);

  loop_state_e     state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [Q_W-1:0]  quiet_q, quiet_d;
  logic            lock_q, lock_d;
  logic            qual_up, qual_dn, qual_ev;
  logic            run;

  assign qual_up = i_up & ~i_down;
  assign qual_dn = i_down & ~i_up;
  assign qual_ev = qual_up | qual_dn;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Scan freezes the FSM; otherwise dropping enable always returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (!i_scan_en) begin
      if (!i_enable) begin
        state_d = IDLE;
      end else begin
        unique case (state_q)
          IDLE:    state_d = ACQUIRE;
          ACQUIRE: if (quiet_q == QUIET_FULL && !qual_ev) state_d = LOCKED;
          LOCKED:  if (qual_ev) state_d = ACQUIRE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    run    = !i_scan_en && i_enable && (state_q != IDLE);
    lock_d = (state_d == LOCKED);
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (i_scan_en) begin
      ctrl_d = {ctrl_q[CTRL_W-2:0], i_scan_in};
    end else if (run && qual_up) begin
      ctrl_d = CTRL_W'(sat_add(int'($signed(ctrl_q)), KI, CTRL_MIN, CTRL_MAX));
    end else if (run && qual_dn) begin
      ctrl_d = CTRL_W'(sat_add(int'($signed(ctrl_q)), -KI, CTRL_MIN, CTRL_MAX));
    end
  end

  always_comb begin
    quiet_d = quiet_q;
    if (!i_scan_en) begin
      if (!run || qual_ev) begin
        quiet_d = '0;
      end else if (quiet_q != QUIET_FULL) begin
        quiet_d = quiet_q + Q_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ctrl_q  <= '0;
      quiet_q <= '0;
      lock_q  <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      quiet_q <= quiet_d;
      lock_q  <= lock_d;
    end
  end

  tt_dco_nco #(
    .ACC_W   (ACC_W),
    .CTRL_W  (CTRL_W),
    .BASE_FCW(BASE_FCW),
    .KP      (KP)
  ) u_nco (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_run   (run),
    .i_up    (qual_up),
    .i_down  (qual_dn),
    .i_ctrl  (ctrl_q),
    .o_clk_fb(o_clk_fb)
  );

  assign o_ctrl     = ctrl_q;
  assign o_lock     = lock_q;
  assign o_scan_out = ctrl_q[CTRL_W-1];

endmodule

// File: tb/tb_tt_dco_loop.sv
// tb/tb_tt_dco_loop.sv - directed self-checking bench for tt_dco_loop
module tb_tt_dco_loop;

  localparam int CTRL_W = 10;

  logic              clk = 1'b0;
  logic              rst, enable, up, down, scan_en, scan_in;
  logic              clk_fb, lock, scan_out;
  logic [CTRL_W-1:0] ctrl;

  int checks = 0;
  int errors = 0;

  tt_dco_loop dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_enable  (enable),
    .i_up      (up),
    .i_down    (down),
    .o_clk_fb  (clk_fb),
    .o_ctrl    (ctrl),
    .o_lock    (lock),
    .i_scan_en (scan_en),
    .i_scan_in (scan_in),
    .o_scan_out(scan_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              en;
    logic              up;
    logic              dn;
    logic              sen;
    logic              sin;
    logic [CTRL_W-1:0] exp_ctrl;
    logic              exp_lock;
  } vec_t;

  vec_t vecs[15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0; up = 1'b0; down = 1'b0; scan_en = 1'b0; scan_in = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Cycles between two consecutive rising edges of the feedback clock; -1 if the window ends first.
  task automatic measure_period(output int per);
    logic prev;
    int   first;
    first = -1;
    per   = -1;
    prev  = clk_fb;
    for (int c = 0; c < 400 && per < 0; c++) begin
      step();
      if (!prev && clk_fb) begin
        if (first < 0) first = c;
        else per = c - first;
      end
      prev = clk_fb;
    end
  endtask

  initial begin
    int          per;
    logic        mono_ok, lock_held, fb_ok, fb0;
    logic signed [CTRL_W-1:0] prev_ctrl;
    logic [CTRL_W-1:0] pattern, captured;

    // en up dn sen sin ctrl lock
    vecs[0]  = '{1, 0, 0, 0, 0, 10'h000, 0};
    vecs[1]  = '{1, 1, 0, 0, 0, 10'h001, 0};
    vecs[2]  = '{1, 1, 0, 0, 0, 10'h002, 0};
    vecs[3]  = '{1, 1, 1, 0, 0, 10'h002, 0};
    vecs[4]  = '{1, 0, 1, 0, 0, 10'h001, 0};
    vecs[5]  = '{1, 0, 1, 0, 0, 10'h000, 0};
    vecs[6]  = '{1, 0, 1, 0, 0, 10'h3FF, 0};
    vecs[7]  = '{0, 1, 0, 0, 0, 10'h3FF, 0};
    vecs[8]  = '{0, 0, 1, 0, 0, 10'h3FF, 0};
    vecs[9]  = '{1, 1, 0, 0, 0, 10'h3FF, 0};
    vecs[10] = '{1, 1, 0, 0, 0, 10'h000, 0};
    vecs[11] = '{1, 1, 0, 1, 1, 10'h001, 0};
    vecs[12] = '{1, 1, 0, 1, 0, 10'h002, 0};
    vecs[13] = '{1, 0, 1, 1, 1, 10'h005, 0};
    vecs[14] = '{1, 0, 0, 0, 0, 10'h005, 0};

    do_reset();
    check("reset_ctrl", 32'(ctrl), 32'h0);
    check("reset_lock", 32'(lock), 32'h0);
    check("reset_clk_fb", 32'(clk_fb), 32'h0);
    check("reset_scan_out", 32'(scan_out), 32'h0);

    for (int i = 0; i < 15; i++) begin
      enable = vecs[i].en; up = vecs[i].up; down = vecs[i].dn;
      scan_en = vecs[i].sen; scan_in = vecs[i].sin;
      step();
      check($sformatf("vec%0d_ctrl", i), 32'(ctrl), 32'(vecs[i].exp_ctrl));
      check($sformatf("vec%0d_lock", i), 32'(lock), 32'(vecs[i].exp_lock));
      check($sformatf("vec%0d_scan_out", i), 32'(scan_out), 32'(vecs[i].exp_ctrl[CTRL_W-1]));
    end

    // Free-running acquisition and lock.
    do_reset();
    enable = 1'b1;
    step();
    repeat (250) step();
    check("acq_not_locked_yet", 32'(lock), 32'h0);
    repeat (10) step();
    check("acq_locked", 32'(lock), 32'h1);
    check("acq_ctrl", 32'(ctrl), 32'h0);
    measure_period(per);
    check_range("period_base", per, 64, 64);

    // Simultaneous up/down is no event: lock holds, ctrl unchanged.
    up = 1'b1; down = 1'b1;
    lock_held = 1'b1;
    repeat (10) begin
      step();
      if (lock !== 1'b1) lock_held = 1'b0;
    end
    check("both_lock_held", 32'(lock_held), 32'h1);
    check("both_ctrl", 32'(ctrl), 32'h0);

    // Single down pulse breaks lock, then relock.
    up = 1'b0; down = 1'b1;
    step();
    down = 1'b0;
    check("dn_pulse_ctrl", 32'(ctrl), 32'h3FF);
    check("dn_pulse_unlock", 32'(lock), 32'h0);
    repeat (250) step();
    check("relock_not_yet", 32'(lock), 32'h0);
    repeat (10) step();
    check("relock", 32'(lock), 32'h1);

    // Hold up: integral saturates high without wrapping.
    up = 1'b1;
    mono_ok = 1'b1;
    prev_ctrl = $signed(ctrl);
    repeat (600) begin
      step();
      if ($signed(ctrl) < prev_ctrl) mono_ok = 1'b0;
      prev_ctrl = $signed(ctrl);
    end
    check("up_no_wrap", 32'(mono_ok), 32'h1);
    check("up_sat_max", 32'(ctrl), 32'd511);
    measure_period(per);
    check_range("period_up_sat", per, 42, 43);

    // Hold down: saturates at the signed minimum.
    up = 1'b0; down = 1'b1;
    repeat (1100) step();
    check("dn_sat_min", 32'(ctrl), 32'h200);
    down = 1'b0;

    // Scan in 10'h155 MSB first, then shift it back out.
    pattern = 10'h155;
    scan_en = 1'b1;
    fb0 = 1'b0;
    fb_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      scan_in = pattern[CTRL_W-1-i];
      step();
      if (i == 0) fb0 = clk_fb;
      else if (clk_fb !== fb0) fb_ok = 1'b0;
    end
    check("scan_in_ctrl", 32'(ctrl), 32'h155);
    scan_in = 1'b0;
    captured = '0;
    for (int i = 0; i < 10; i++) begin
      captured[CTRL_W-1-i] = scan_out;
      step();
      if (clk_fb !== fb0) fb_ok = 1'b0;
    end
    check("scan_out_word", 32'(captured), 32'h155);
    check("scan_out_ctrl_zero", 32'(ctrl), 32'h0);
    check("scan_phase_held", 32'(fb_ok), 32'h1);
    scan_en = 1'b0;

    // Reset mid-scan with ctrl at 200.
    do_reset();
    enable = 1'b1;
    step();
    up = 1'b1;
    repeat (200) step();
    up = 1'b0;
    check("ctrl_200", 32'(ctrl), 32'd200);
    scan_en = 1'b1; scan_in = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    step();
    check("midscan_rst_ctrl", 32'(ctrl), 32'h0);
    check("midscan_rst_lock", 32'(lock), 32'h0);
    check("midscan_rst_clk_fb", 32'(clk_fb), 32'h0);
    check("midscan_rst_scan_out", 32'(scan_out), 32'h0);
    rst = 1'b0; scan_en = 1'b0; scan_in = 1'b0;
    enable = 1'b1; up = 1'b1;
    step();
    check("post_rst_idle_hold", 32'(ctrl), 32'h0);
    step();
    check("post_rst_acquire_step", 32'(ctrl), 32'h1);
    up = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_dco_loop.md
TT_DCO_LOOP -- requirements
Module: tt_dco_loop

Interface
REQ-001 Parameter ACC_W, default 16: phase accumulator width, bits.
REQ-002 Parameter CTRL_W, default 10: signed integral control word width.
REQ-003 Parameter BASE_FCW, default 16'h0400: free-running frequency control word.
REQ-004 Parameter KI, default 1: integral step per up/down cycle.
REQ-005 Parameter KP, default 16: proportional FCW kick per up/down cycle.
REQ-006 Parameter LOCK_CNT, default 256: consecutive quiet cycles needed to declare lock.
REQ-007 Ports (one clock; reset is synchronous and active-high):
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_enable  in  1  loop enable; 0 holds ctrl and phase
- i_up  in  1  PFD up pulse, feedback lags
- i_down  in  1  PFD down pulse, feedback leads
- o_clk_fb  out  1  generated feedback clock to PFD
- o_ctrl  out  CTRL_W  current integral word, signed
- o_lock  out  1  lock indicator
- i_scan_en  in  1  scan shift enable
- i_scan_in  in  1  scan serial in
- o_scan_out  out  1  scan serial out

Function
REQ-008 FSM states SHALL be IDLE, ACQUIRE, LOCKED; IDLE->ACQUIRE when i_enable=1; ACQUIRE->LOCKED when quiet counter reaches LOCK_CNT; LOCKED->ACQUIRE on any qualified up/down; any state->IDLE when i_enable=0.
REQ-009 Qualified up SHALL be i_up&&!i_down, qualified down i_down&&!i_up; both high or both low = no event.
REQ-010 In ACQUIRE/LOCKED, ctrl SHALL update next cycle: +KI on up, -KI on down, saturating at signed CTRL_W min/max (no wrap).
REQ-011 FCW = BASE_FCW + sign_ext(ctrl) + prop, prop = +KP on qualified up, -KP on qualified down, else 0, same cycle as the event (combinational from inputs).
REQ-012 FCW SHALL be computed in ACC_W+2 signed bits and clamped to [1, 2^(ACC_W-1)-1].
REQ-013 Phase accumulator SHALL add FCW each cycle modulo 2^ACC_W in ACQUIRE/LOCKED; held in IDLE.
REQ-014 o_clk_fb SHALL be registered phase MSB; output period = 2^ACC_W/FCW cycles.
REQ-015 Quiet counter SHALL increment on no-event cycles, saturate at LOCK_CNT, clear to 0 on qualified event or leaving ACQUIRE/LOCKED.
REQ-016 o_lock SHALL be 1 only in LOCKED, registered.
REQ-017 i_scan_en=1 SHALL override function: ctrl shifts left one bit per cycle with i_scan_in into LSB, o_scan_out = ctrl MSB; phase, FSM, quiet counter held.
REQ-018 Scan SHALL take priority over i_enable and up/down; i_rst over everything.

Reset
REQ-019 i_rst high at a clock edge SHALL set ctrl=0, phase=0, quiet=0, FSM=IDLE.
REQ-020 Outputs after reset: o_clk_fb=0, o_ctrl=0, o_lock=0, o_scan_out=0.
REQ-021 Reset asserted mid-operation (including mid-scan) SHALL take effect on that edge; partial scan data discarded.

Structure
REQ-022 Package tt_pll_pkg SHALL hold the state enum, default parameter constants and the saturating-add function.
REQ-023 Sub-module tt_dco_nco SHALL hold phase accumulator, FCW clamp and o_clk_fb register; tt_dco_loop holds FSM, integral, lock and scan logic.

Verification (defaults)
REQ-024 Reset, i_enable=1, no pulses -> o_clk_fb period 64 cycles, o_ctrl=0, o_lock=1 after 256 quiet cycles past ACQUIRE entry.
REQ-025 i_up held 600 cycles -> o_ctrl saturates at 511, never wraps; period drops to 65536/(1024+511+16)=~42 cycles.
REQ-026 i_up=i_down=1 for 10 cycles -> o_ctrl unchanged, quiet counter increments, no prop kick.
REQ-027 In LOCKED, one i_down pulse -> o_lock=0 next cycle, o_ctrl decrements by 1, relock after 256 quiet cycles.
REQ-028 i_scan_en=1, shift 10'h155 LSB-last over 10 cycles -> o_ctrl=10'h155, phase unchanged; further 10 shifts reproduce 10'h155 on o_scan_out MSB-first.
REQ-029 i_rst pulsed while o_ctrl=200 and mid-scan -> all outputs 0 next cycle, FSM IDLE.
